// File: rtl/mux_cfg_chain_ctrl_if.sv
// Loader-side word handshake for the MUX2 configuration-chain controller.
// The master drives a word and its valid bit; the slave returns ready.
interface mux_cfg_chain_ctrl_if #(
  parameter int WORD_W = 8
);
  logic [WORD_W-1:0] DIN;
  logic              DIN_VALID;
  logic              DIN_READY;

  modport master (
    output DIN,
    output DIN_VALID,
    input  DIN_READY
  );

  modport slave (
    input  DIN,
    input  DIN_VALID,
    output DIN_READY
  );
endinterface

// File: rtl/mux_cfg_chain_ctrl.sv
// Serializes loader words MSB-first onto a mux select shift chain.
// Define MUX_CFG_READBACK_EN to add a parity readback over recirculation.
module mux_cfg_chain_ctrl #(
  parameter int CHAIN_LEN = 16,
  parameter int WORD_W    = 8
) (
  input  logic CK,
  input  logic RST,
  input  logic START,
  input  logic ABORT,
  mux_cfg_chain_ctrl_if.slave ld,
  output logic CHAIN_SI,
  output logic CHAIN_SE,
  input  logic CHAIN_SO,
  output logic BUSY,
  output logic CFG_DONE,
  output logic ERR
);

  localparam int CW = $clog2(CHAIN_LEN + 1);
  typedef logic [CW-1:0] cnt_t;
  localparam cnt_t LEN_C = cnt_t'(CHAIN_LEN);
  localparam cnt_t WW_C  =
    (WORD_W > CHAIN_LEN) ? LEN_C : cnt_t'(WORD_W);

  typedef enum logic [2:0] {
    S_IDLE,
    S_LOAD,
    S_SHIFT,
`ifdef MUX_CFG_READBACK_EN
    S_VERIFY,
`endif
    S_DONE
  } state_e;

  state_e            state_q, state_d;
  cnt_t              bits_q, bits_d;
  cnt_t              left_q, left_d;
  logic [WORD_W-1:0] word_q, word_d;
  logic              err_q, err_d;
  logic              rdy, se, si, done;
  cnt_t              rem_w;
  logic              last;

  assign rem_w = LEN_C - bits_q;
  assign last  = (bits_q == LEN_C - cnt_t'(1));

`ifdef MUX_CFG_READBACK_EN
  logic par_si_q, par_si_d;
  logic par_so_q, par_so_d;
`else
  logic unused_so;
  assign unused_so = CHAIN_SO;
`endif

  always_comb begin
    state_d = state_q;
    bits_d  = bits_q;
    left_d  = left_q;
    word_d  = word_q;
    err_d   = err_q;
    rdy     = 1'b0;
    se      = 1'b0;
    si      = 1'b0;
    done    = 1'b0;
`ifdef MUX_CFG_READBACK_EN
    par_si_d = par_si_q;
    par_so_d = par_so_q;
`endif
    unique case (state_q)
      S_IDLE: begin
        if (START) begin
          state_d = S_LOAD;
          bits_d  = '0;
          err_d   = 1'b0;
`ifdef MUX_CFG_READBACK_EN
          par_si_d = 1'b0;
          par_so_d = 1'b0;
`endif
        end
      end
      S_LOAD: begin
        rdy = 1'b1;
        if (ld.DIN_VALID) begin
          word_d  = ld.DIN;
          left_d  = (rem_w < WW_C) ? rem_w : WW_C;
          state_d = S_SHIFT;
        end
      end
      S_SHIFT: begin
        se     = 1'b1;
        si     = word_q[WORD_W-1];
        word_d = word_q << 1;
        bits_d = bits_q + cnt_t'(1);
        left_d = left_q - cnt_t'(1);
`ifdef MUX_CFG_READBACK_EN
        par_si_d = par_si_q ^ si;
        if (last) begin
          state_d = S_VERIFY;
          bits_d  = '0;
        end
`else
        if (last) begin
          state_d = S_DONE;
        end
`endif
        else if (left_q == cnt_t'(1)) begin
          state_d = S_LOAD;
        end
      end
`ifdef MUX_CFG_READBACK_EN
      // Recirculate the tail so the chain ends where it started.
      S_VERIFY: begin
        se       = 1'b1;
        si       = CHAIN_SO;
        bits_d   = bits_q + cnt_t'(1);
        par_so_d = par_so_q ^ CHAIN_SO;
        if (last) begin
          if (par_so_d != par_si_q) begin
            err_d   = 1'b1;
            state_d = S_IDLE;
          end else begin
            state_d = S_DONE;
          end
        end
      end
`endif
      S_DONE: begin
        done    = 1'b1;
        state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
    // Abort wins over every transition, including a same-cycle handshake.
    if (ABORT && state_q != S_IDLE) begin
      state_d = S_IDLE;
      err_d   = 1'b1;
      rdy     = 1'b0;
      done    = 1'b0;
      word_d  = word_q;
      left_d  = left_q;
    end
  end

  always_ff @(posedge CK) begin
    if (RST) begin
      state_q <= S_IDLE;
      bits_q  <= '0;
      left_q  <= '0;
      word_q  <= '0;
      err_q   <= 1'b0;
`ifdef MUX_CFG_READBACK_EN
      par_si_q <= 1'b0;
      par_so_q <= 1'b0;
`endif
    end else begin
      state_q <= state_d;
      bits_q  <= bits_d;
      left_q  <= left_d;
      word_q  <= word_d;
      err_q   <= err_d;
`ifdef MUX_CFG_READBACK_EN
      par_si_q <= par_si_d;
      par_so_q <= par_so_d;
`endif
    end
  end

  assign ld.DIN_READY = rdy;
  assign CHAIN_SI     = si;
  assign CHAIN_SE     = se;
  assign BUSY         = (state_q != S_IDLE);
  assign CFG_DONE     = done;
  assign ERR          = err_q;

endmodule

// File: tb/tb_mux_cfg_chain_ctrl.sv
// Bench: two controllers (16-bit and 12-bit chains) with chain models,
// random words, stalls, aborts and resets checked against bit streams.
module tb_mux_cfg_chain_ctrl;

  localparam int LA = 16;
  localparam int LB = 12;
  localparam int W  = 8;
`ifdef MUX_CFG_READBACK_EN
  localparam int RB = 1;
`else
  localparam int RB = 0;
`endif

  logic          CK = 1'b0;
  logic          RST;
  logic [1:0]    start, abort, se, si, busy, done, err, so;
  logic [W-1:0]  din;
  logic          vld;
  logic          sel;
  logic [LA-1:0] cha;
  logic [LB-1:0] chb;
  logic [W-1:0]  words [4];
  int            stalls [4];
  int            total = 0;
  int            bad   = 0;

  always #5 CK = ~CK;

  mux_cfg_chain_ctrl_if #(.WORD_W(W)) ifa ();
  mux_cfg_chain_ctrl_if #(.WORD_W(W)) ifb ();

  assign ifa.DIN       = din;
  assign ifb.DIN       = din;
  assign ifa.DIN_VALID = vld && !sel;
  assign ifb.DIN_VALID = vld && sel;

  mux_cfg_chain_ctrl #(.CHAIN_LEN(LA), .WORD_W(W)) dut_a (
    .CK(CK), .RST(RST), .START(start[0]), .ABORT(abort[0]),
    .ld(ifa), .CHAIN_SI(si[0]), .CHAIN_SE(se[0]), .CHAIN_SO(so[0]),
    .BUSY(busy[0]), .CFG_DONE(done[0]), .ERR(err[0])
  );

  mux_cfg_chain_ctrl #(.CHAIN_LEN(LB), .WORD_W(W)) dut_b (
    .CK(CK), .RST(RST), .START(start[1]), .ABORT(abort[1]),
    .ld(ifb), .CHAIN_SI(si[1]), .CHAIN_SE(se[1]), .CHAIN_SO(so[1]),
    .BUSY(busy[1]), .CFG_DONE(done[1]), .ERR(err[1])
  );

  // Select-bit chain models: first bit shifted ends at the tail.
  always @(posedge CK) begin
    if (se[0]) cha <= {cha[LA-2:0], si[0]};
    if (se[1]) chb <= {chb[LB-2:0], si[1]};
  end
  assign so[0] = cha[LA-1];
  assign so[1] = chb[LB-1];

  logic o_se, o_si, o_busy, o_done, o_err, o_rdy;
  assign o_se   = sel ? se[1]   : se[0];
  assign o_si   = sel ? si[1]   : si[0];
  assign o_busy = sel ? busy[1] : busy[0];
  assign o_done = sel ? done[1] : done[0];
  assign o_err  = sel ? err[1]  : err[0];
  assign o_rdy  = sel ? ifb.DIN_READY : ifa.DIN_READY;

  task automatic chk(input string tag, input logic [31:0] got,
                     input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  // mode: 0 normal, 1 abort on shift number ab_at, 2 abort in 2nd LOAD
  task automatic run_load(input bit s, input int mode, input int ab_at,
                          input bit poke);
    int len, rem, nb, k, cyc, nsh, idx, st_left, dn, dcyc;
    int endc, abc, ovl, exp_cyc, exp_nsh;
    logic [31:0] gv, ev, chv;
    bit ab, fin;
    sel = s;
    len = s ? LB : LA;
    ev = 0;
    for (int i = 0; i < len; i++)
      ev = {ev[30:0], words[i / W][W - 1 - (i % W)]};
    exp_cyc = 1;
    rem = len;
    k = 0;
    while (rem > 0) begin
      nb = (rem < W) ? rem : W;
      exp_cyc += stalls[k] + 1 + nb;
      rem -= nb;
      k++;
    end
    exp_cyc += RB * len;
    exp_nsh = len * (1 + RB);
    @(negedge CK);
    start[s] = 1'b1;
    vld = 1'b0;
    #1 chk("pre_busy", 32'(o_busy), 0);
    cyc = 0; nsh = 0; idx = 0; dn = 0; dcyc = 0; endc = 0;
    abc = 0; ovl = 0; gv = 0; fin = 0;
    st_left = stalls[0];
    while (!fin && cyc < 300) begin
      @(negedge CK);
      start = '0; abort = '0; vld = 1'b0;
      cyc++;
      #1;
      if (!o_busy) begin
        endc = cyc;
        fin = 1;
      end else begin
        if (cyc == 1) chk("err_clr", 32'(o_err), 0);
        if (o_done) begin dn++; dcyc = cyc; end
        ab = (mode == 1 && o_se && nsh == ab_at) ||
             (mode == 2 && o_rdy && idx == 1);
        if (o_se) begin
          if (nsh < len) gv = {gv[30:0], o_si};
          nsh++;
        end
        if (poke && o_se && nsh == 3) start[s] = 1'b1;
        din = words[idx];
        vld = (st_left == 0);
        abort[s] = ab;
        #1;
        if (ab) abc = cyc;
        if (ab && mode == 2) chk("abort_rdy", 32'(o_rdy), 0);
        if (o_rdy && o_se) ovl++;
        if (o_rdy && vld) begin
          idx++;
          st_left = stalls[idx];
        end else if (o_rdy) begin
          st_left--;
        end
      end
    end
    chk("finished", 32'(fin), 1);
    chk("rdy_se_overlap", ovl, 0);
    chv = s ? 32'(chb) : 32'(cha);
    if (mode == 0) begin
      chk("shifts", nsh, exp_nsh);
      chk("si_bits", gv, ev);
      chk("done_cnt", dn, 1);
      chk("done_cyc", dcyc, exp_cyc);
      chk("busy_end", endc, exp_cyc + 1);
      chk("err_ok", 32'(o_err), 0);
      chk("chain", chv, ev);
    end else begin
      chk("abort_shifts", nsh, (mode == 1) ? ab_at + 1 : W);
      chk("abort_done", dn, 0);
      chk("abort_end", endc, abc + 1);
      chk("abort_err", 32'(o_err), 1);
    end
  endtask

  task automatic set_words(input logic [W-1:0] w0, input logic [W-1:0] w1,
                           input int s0, input int s1);
    words[0] = w0; words[1] = w1; words[2] = '0; words[3] = '0;
    stalls[0] = s0; stalls[1] = s1; stalls[2] = 0; stalls[3] = 0;
  endtask

  initial begin
    RST = 1'b1; start = '0; abort = '0; din = '0; vld = 1'b0; sel = 1'b0;
    cha = '0; chb = '0;
    repeat (3) @(negedge CK);
    #1;
    chk("rst_a", {busy[0], se[0], si[0], done[0], err[0], ifa.DIN_READY}, 0);
    chk("rst_b", {busy[1], se[1], si[1], done[1], err[1], ifb.DIN_READY}, 0);
    RST = 1'b0;

    set_words(8'hA5, 8'h3C, 0, 0);
    run_load(1'b0, 0, 0, 1'b0);
    set_words(8'hFF, 8'h90, 0, 0);
    run_load(1'b1, 0, 0, 1'b0);
    set_words(8'h6B, 8'hD2, 0, 5);
    run_load(1'b0, 0, 0, 1'b1);
    set_words(8'h81, 8'h7E, 0, 0);
    run_load(1'b0, 1, 4, 1'b0);
    set_words(8'hC3, 8'h18, 1, 0);
    run_load(1'b0, 0, 0, 1'b0);
    set_words(8'h55, 8'hAA, 0, 2);
    run_load(1'b1, 2, 0, 1'b0);

    // Reset in the middle of shifting, with START asserted alongside.
    sel = 1'b0;
    @(negedge CK);
    start[0] = 1'b1; din = 8'h5A; vld = 1'b1;
    repeat (5) begin
      @(negedge CK);
      start[0] = 1'b0;
    end
    #1 chk("mid_shift", 32'(se[0]), 1);
    @(negedge CK);
    RST = 1'b1; start[0] = 1'b1;
    @(negedge CK);
    RST = 1'b0; start[0] = 1'b0; vld = 1'b0;
    #1;
    chk("rst_mid", {busy[0], se[0], si[0], done[0], err[0], ifa.DIN_READY}, 0);

    for (int it = 0; it < 24; it++) begin
      int m, lim;
      bit s;
      s = 1'($urandom_range(0, 1));
      lim = s ? LB : LA;
      set_words(W'($urandom), W'($urandom),
                $urandom_range(0, 3), $urandom_range(0, 3));
      m = ($urandom_range(0, 3) == 0) ? int'($urandom_range(1, 2)) : 0;
      run_load(s, m, $urandom_range(0, lim - 1), 1'($urandom_range(0, 1)));
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
